axi_stream_strip_header: RTL and testbench
==========================================

Name: axi_stream_strip_header

Overview:
- Removes a 1..DATA_BYTE_WD-byte header from the front of each AXI-Stream packet, then repacks the remaining payload MSB-first with no gaps.
- Inverse of the header-insert block: the insert side prepends header bytes, this block strips them on the receive end of the same stream format.
- Big-endian byte order: the byte in data[DATA_WD-1 -: 8] comes first.
- keep is high-aligned on every beat; only the last beat may be partial.

Parameters:
- DATA_WD, 32, stream data width in bits. Must be a multiple of 8.
- DATA_BYTE_WD, DATA_WD/8, byte lanes per beat (B).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input beat data.
- keep_in  in  DATA_BYTE_WD  input byte enables, high-aligned.
- last_in  in  1  last beat of the input packet.
- ready_in  out  1  input beat accepted when valid_in&&ready_in.
- valid_strip  in  1  strip command valid, one per packet.
- keep_strip  in  DATA_BYTE_WD  header length as low-aligned mask (0001..1111); N = popcount.
- ready_strip  out  1  strip command accepted.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  output data, MSB-first packed.
- keep_out  out  DATA_BYTE_WD  output byte enables, high-aligned.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream ready.

Behaviour:
- Reset: state IDLE, residual buffer cleared. All of ready_in, ready_strip, valid_out, data_out, keep_out, last_out drive 0.
- Reset asserted mid-packet aborts the packet immediately. No partial output follows reset.

State machine: IDLE -> HEAD -> BODY -> FLUSH.
- IDLE: ready_strip=1. Accepting a command latches N, then moves to HEAD.
- keep_strip=0000 sets N=0: bypass mode. Every beat passes through unchanged, with one cycle of register latency.
- HEAD: accepts the first beat.
  - The top N bytes are dropped.
  - The low B-N bytes go to the residual buffer.
  - No output is produced unless last_in=1.
- BODY: for each accepted beat, out = {residual (B-N bytes), top N bytes of beat}.
  - The low B-N bytes of the beat become the new residual.
- Last beat handling, with K = popcount(keep_in):
  - K<=N: emit one beat of B-N+K bytes with last_out=1, then go to IDLE.
  - K>N: emit a full beat, then go to FLUSH.
- FLUSH: ready_in=0. Emit the residual K-N bytes with last_out=1, then go to IDLE.
- HEAD with last_in=1:
  - K>N: go to FLUSH and emit K-N bytes.
  - K<=N: the packet has no payload. Emit no output beat and return to IDLE.

Output and handshake rules:
- The output is a single registered stage.
- ready_in = (state is HEAD or BODY) && (!valid_out || ready_out).
- While valid_out=1 and ready_out=0, data_out, keep_out and last_out hold stable.
- Unused low bytes of data_out drive 0.
- The next command is accepted no earlier than the cycle after the final output beat is accepted.
- Latency from an input beat to the output carrying its bytes: 1 cycle, or 2 cycles for the FLUSH beat.
- Throughput: one beat per clock when ready_out=1.
- Input beats with valid_in=1 in IDLE are not accepted (ready_in=0).

Optional Feature:
- Macro: STRIP_HEADER_OUT_EN.
- Defined: adds the following ports:
  - valid_header (out, 1)
  - data_header (out, DATA_WD)
  - keep_header (out, DATA_BYTE_WD)
  - ready_header (in, 1)
- Header behaviour when defined:
  - Stripped bytes are presented low-aligned, e.g. N=2 gives keep_header=0011 and data_header={16'h0, byte0, byte1}.
  - valid_header rises the cycle after the HEAD beat is accepted and holds until ready_header.
  - The HEAD beat is accepted only when the header register is empty or being drained.
  - For a short packet with K<N, keep_header masks only the K captured bytes.
  - In bypass mode (N=0) no header beat is produced.
- Undefined: header bytes are discarded and there are no header ports.

Test Plan:
- keep_strip=0011. Input A1A2A3A4/1111, B1B2B3B4/1111, C1C2C3C4/1100 last.
  - Output: A3A4B1B2/1111, then B3B4C1C2/1111 last.
  - With macro: header 0000A1A2/0011.
- keep_strip=0001, same beats with the last beat C1C2C3xx/1110.
  - Output: A2A3A4B1/1111, B2B3B4C1/1111, then FLUSH beat C2C3_0000/1100 last.
- keep_strip=1111, same three beats (last keep 1100).
  - Output: B1B2B3B4/1111, then C1C2_0000/1100 last.
- keep_strip=0001, single beat A1A2A3A4/1111 last -> one beat A2A3A4_00/1110 last.
- keep_strip=0111, single beat A1A2_0000/1100 last -> no output beat.
  - Next command accepted; with macro, header 00A1A2_00/0110 is not valid. keep_header=0011 with data 0000A1A2.
- Backpressure: hold ready_out=0 for 3 cycles mid-packet.
  - Output data holds stable and ready_in=0.
  - After release, sequence is identical to the first scenario.
- Reset asserted during BODY.
  - Next cycle: valid_out=0 and ready_strip=0.
  - After deassert, a new packet strips correctly.

Source files
------------

// File: rtl/axi_stream_strip_header_if.sv
// Port bundle for axi_stream_strip_header: input stream, strip command and output stream.
// Header side-band signals are present only when STRIP_HEADER_OUT_EN is defined.
interface axi_stream_strip_header_if #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_strip;
  logic [DATA_BYTE_WD-1:0] keep_strip;
  logic                    ready_strip;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

`ifdef STRIP_HEADER_OUT_EN
  logic                    valid_header;
  logic [DATA_WD-1:0]      data_header;
  logic [DATA_BYTE_WD-1:0] keep_header;
  logic                    ready_header;
`endif

  // Block side
  modport slave (
`ifdef STRIP_HEADER_OUT_EN
    output valid_header, data_header, keep_header,
    input  ready_header,
`endif
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    input  valid_strip, keep_strip,
    output ready_strip,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out
  );

  // Environment side
  modport master (
`ifdef STRIP_HEADER_OUT_EN
    input  valid_header, data_header, keep_header,
    output ready_header,
`endif
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    output valid_strip, keep_strip,
    input  ready_strip,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out
  );
endinterface

// File: rtl/axi_stream_strip_header.sv
// Strips an N-byte header (N from keep_strip) off each AXI-Stream packet and repacks the payload.
// Define STRIP_HEADER_OUT_EN to expose the stripped header bytes on a separate low-aligned port.
module axi_stream_strip_header #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_stream_strip_header_if.slave bus
);
  localparam int unsigned   CW    = $clog2(DATA_BYTE_WD + 1);
  localparam logic [CW-1:0] B_CNT = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, FLUSH} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           n_q, n_nx;
  logic [CW-1:0]           rem_q, rem_nx;
  logic [DATA_WD-1:0]      res_q, res_nx;
  logic                    out_valid_q, out_valid_nx;
  logic [DATA_WD-1:0]      out_data_q, out_data_nx;
  logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_nx;
  logic                    out_last_q, out_last_nx;

  logic [CW-1:0]           k_cnt;
  logic [CW-1:0]           tail_cnt;
  logic [DATA_WD-1:0]      data_m;
  logic [DATA_WD-1:0]      joined;
  logic                    out_room;
  logic                    hdr_room;
  logic                    ready_in_c;
  logic                    ready_strip_c;
  logic                    in_fire;
  logic                    strip_fire;

  function automatic logic [CW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) c = c + CW'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] hi_mask(input logic [CW-1:0] c);
    return ~({DATA_BYTE_WD{1'b1}} >> c);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] lo_mask(input logic [CW-1:0] c);
    return ~({DATA_BYTE_WD{1'b1}} << c);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_bits(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Disabled lanes are zeroed so packed outputs never carry stale bytes.
  assign k_cnt    = popcount(bus.keep_in);
  assign tail_cnt = B_CNT - n_q;
  assign data_m   = bus.data_in & byte_bits(bus.keep_in);
  assign joined   = res_q | (data_m >> {tail_cnt, 3'b000});
  assign out_room = !out_valid_q || bus.ready_out;

  assign ready_in_c    = !rst && out_room &&
                         ((state == BODY) || ((state == HEAD) && ((n_q == '0) || hdr_room)));
  assign ready_strip_c = !rst && (state == IDLE) && !out_valid_q;
  assign in_fire       = bus.valid_in && ready_in_c;
  assign strip_fire    = bus.valid_strip && ready_strip_c;

  assign bus.ready_in    = ready_in_c;
  assign bus.ready_strip = ready_strip_c;
  assign bus.valid_out   = out_valid_q;
  assign bus.data_out    = out_data_q;
  assign bus.keep_out    = out_keep_q;
  assign bus.last_out    = out_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      n_q         <= '0;
      rem_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state       <= state_nx;
      n_q         <= n_nx;
      rem_q       <= rem_nx;
      res_q       <= res_nx;
      out_valid_q <= out_valid_nx;
      out_data_q  <= out_data_nx;
      out_keep_q  <= out_keep_nx;
      out_last_q  <= out_last_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    n_nx         = n_q;
    rem_nx       = rem_q;
    res_nx       = res_q;
    out_valid_nx = out_valid_q && !bus.ready_out;
    out_data_nx  = out_data_q;
    out_keep_nx  = out_keep_q;
    out_last_nx  = out_last_q;

    unique case (state)
      IDLE: begin
        if (strip_fire) begin
          n_nx     = popcount(bus.keep_strip);
          state_nx = HEAD;
        end
      end

      HEAD, BODY: begin
        if (in_fire) begin
          if (n_q == '0) begin
            // Bypass: beat goes straight through the output register.
            out_valid_nx = 1'b1;
            out_data_nx  = bus.data_in;
            out_keep_nx  = bus.keep_in;
            out_last_nx  = bus.last_in;
            state_nx     = bus.last_in ? IDLE : BODY;
          end else begin
            res_nx = data_m << {n_q, 3'b000};
            if (state == HEAD) begin
              if (!bus.last_in) begin
                state_nx = BODY;
              end else if (k_cnt > n_q) begin
                rem_nx   = k_cnt - n_q;
                state_nx = FLUSH;
              end else begin
                state_nx = IDLE;
              end
            end else begin
              out_valid_nx = 1'b1;
              out_data_nx  = joined;
              out_keep_nx  = '1;
              out_last_nx  = 1'b0;
              if (bus.last_in) begin
                if (k_cnt > n_q) begin
                  rem_nx   = k_cnt - n_q;
                  state_nx = FLUSH;
                end else begin
                  out_keep_nx = hi_mask(tail_cnt + k_cnt);
                  out_last_nx = 1'b1;
                  state_nx    = IDLE;
                end
              end
            end
          end
        end
      end

      FLUSH: begin
        if (out_room) begin
          out_valid_nx = 1'b1;
          out_data_nx  = res_q;
          out_keep_nx  = hi_mask(rem_q);
          out_last_nx  = 1'b1;
          state_nx     = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

`ifdef STRIP_HEADER_OUT_EN
  logic                    hdr_valid_q, hdr_valid_nx;
  logic [DATA_WD-1:0]      hdr_data_q, hdr_data_nx;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_nx;
  logic [CW-1:0]           hdr_cnt;
  logic [CW-1:0]           hdr_shift;

  // A short final HEAD beat only yields the bytes it actually carries.
  assign hdr_cnt   = (bus.last_in && (k_cnt < n_q)) ? k_cnt : n_q;
  assign hdr_shift = B_CNT - hdr_cnt;
  assign hdr_room  = !hdr_valid_q || bus.ready_header;

  assign bus.valid_header = hdr_valid_q;
  assign bus.data_header  = hdr_data_q;
  assign bus.keep_header  = hdr_keep_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
    end else begin
      hdr_valid_q <= hdr_valid_nx;
      hdr_data_q  <= hdr_data_nx;
      hdr_keep_q  <= hdr_keep_nx;
    end
  end

  always_comb begin
    hdr_valid_nx = hdr_valid_q && !bus.ready_header;
    hdr_data_nx  = hdr_data_q;
    hdr_keep_nx  = hdr_keep_q;
    if ((state == HEAD) && in_fire && (n_q != '0)) begin
      hdr_valid_nx = 1'b1;
      hdr_data_nx  = data_m >> {hdr_shift, 3'b000};
      hdr_keep_nx  = lo_mask(hdr_cnt);
    end
  end
`else
  assign hdr_room = 1'b1;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: directed packets push expected beats,
// independent monitors pop and compare every accepted output (and header) beat.
module tb_axi_stream_strip_header;
  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [3:0]  keep;
    logic [31:0] data;
  } hdr_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    tests = 0;
  int    errors = 0;
  beat_t oq[$];
  hdr_t  hq[$];

  axi_stream_strip_header_if #(.DATA_WD(32)) bus ();

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void exp_out(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    oq.push_back(b);
  endfunction

  function automatic void exp_hdr(input logic [31:0] d, input logic [3:0] k);
    hdr_t h;
    h.data = d;
    h.keep = k;
    hq.push_back(h);
  endfunction

  task automatic send_cmd(input logic [3:0] ks);
    bit ok;
    ok = 1'b0;
    bus.valid_strip = 1'b1;
    bus.keep_strip  = ks;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus.ready_strip;
      @(posedge clk);
      #1;
    end
    bus.valid_strip = 1'b0;
    chk("cmd_accept_timeout", 64'(ok), 64'(1'b1));
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = l;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus.ready_in;
      @(posedge clk);
      #1;
    end
    bus.valid_in = 1'b0;
    chk("beat_accept_timeout", 64'(ok), 64'(1'b1));
  endtask

  task automatic pkt_abc_n2();
    exp_out(32'hA3A4B1B2, 4'b1111, 1'b0);
    exp_out(32'hB3B4C1C2, 4'b1111, 1'b1);
    exp_hdr(32'h0000A1A2, 4'b0011);
    send_cmd(4'b0011);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
    send_beat(32'hB1B2B3B4, 4'b1111, 1'b0);
    send_beat(32'hC1C2C3C4, 4'b1100, 1'b1);
  endtask

  // Output stream monitor
  initial begin : out_mon
    beat_t got;
    beat_t want;
    forever begin
      @(negedge clk);
      if (bus.valid_out && bus.ready_out) begin
        got.data = bus.data_out;
        got.keep = bus.keep_out;
        got.last = bus.last_out;
        tests++;
        if (oq.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got data=%h keep=%b last=%b, expected no beat",
                   got.data, got.keep, got.last);
        end else begin
          want = oq.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL out_beat: got data=%h keep=%b last=%b expected data=%h keep=%b last=%b",
                     got.data, got.keep, got.last, want.data, want.keep, want.last);
          end
        end
      end
    end
  end

`ifdef STRIP_HEADER_OUT_EN
  // Header stream monitor
  initial begin : hdr_mon
    hdr_t got;
    hdr_t want;
    forever begin
      @(negedge clk);
      if (bus.valid_header && bus.ready_header) begin
        got.data = bus.data_header;
        got.keep = bus.keep_header;
        tests++;
        if (hq.size() == 0) begin
          errors++;
          $display("FAIL hdr_unexpected: got data=%h keep=%b, expected no header", got.data, got.keep);
        end else begin
          want = hq.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL hdr_beat: got data=%h keep=%b expected data=%h keep=%b",
                     got.data, got.keep, want.data, want.keep);
          end
        end
      end
    end
  end
`endif

  initial begin : stim
    bit seen;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.keep_in     = '0;
    bus.last_in     = 1'b0;
    bus.valid_strip = 1'b0;
    bus.keep_strip  = '0;
    bus.ready_out   = 1'b1;
`ifdef STRIP_HEADER_OUT_EN
    bus.ready_header = 1'b1;
`endif

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_in",    64'(bus.ready_in),    64'(1'b0));
    chk("rst_ready_strip", 64'(bus.ready_strip), 64'(1'b0));
    chk("rst_valid_out",   64'(bus.valid_out),   64'(1'b0));
    chk("rst_data_out",    64'(bus.data_out),    64'(32'h0));
    chk("rst_keep_out",    64'(bus.keep_out),    64'(4'h0));
    chk("rst_last_out",    64'(bus.last_out),    64'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Data offered while IDLE must not be taken
    bus.valid_in = 1'b1;
    bus.data_in  = 32'hDEADBEEF;
    bus.keep_in  = 4'b1111;
    @(negedge clk);
    chk("idle_ready_in", 64'(bus.ready_in), 64'(1'b0));
    chk("idle_ready_strip", 64'(bus.ready_strip), 64'(1'b1));
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;

    // N=2, three beats
    pkt_abc_n2();

    // N=1, last beat forces FLUSH
    exp_out(32'hA2A3A4B1, 4'b1111, 1'b0);
    exp_out(32'hB2B3B4C1, 4'b1111, 1'b0);
    exp_out(32'hC2C30000, 4'b1100, 1'b1);
    exp_hdr(32'h000000A1, 4'b0001);
    send_cmd(4'b0001);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
    send_beat(32'hB1B2B3B4, 4'b1111, 1'b0);
    send_beat(32'hC1C2C3EE, 4'b1110, 1'b1);

    // N=4, whole first beat is header
    exp_out(32'hB1B2B3B4, 4'b1111, 1'b0);
    exp_out(32'hC1C20000, 4'b1100, 1'b1);
    exp_hdr(32'hA1A2A3A4, 4'b1111);
    send_cmd(4'b1111);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
    send_beat(32'hB1B2B3B4, 4'b1111, 1'b0);
    send_beat(32'hC1C2C3C4, 4'b1100, 1'b1);

    // N=1, single full last beat
    exp_out(32'hA2A3A400, 4'b1110, 1'b1);
    exp_hdr(32'h000000A1, 4'b0001);
    send_cmd(4'b0001);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b1);

    // N=3, single short beat: no payload at all
    exp_hdr(32'h0000A1A2, 4'b0011);
    send_cmd(4'b0111);
    send_beat(32'hA1A20000, 4'b1100, 1'b1);
    @(negedge clk);
    chk("empty_pkt_ready_strip", 64'(bus.ready_strip), 64'(1'b1));
    chk("empty_pkt_valid_out",   64'(bus.valid_out),   64'(1'b0));
    @(posedge clk);
    #1;

    // Bypass (N=0)
    exp_out(32'hD1D2D3D4, 4'b1111, 1'b0);
    exp_out(32'hE1E20000, 4'b1100, 1'b1);
    send_cmd(4'b0000);
    send_beat(32'hD1D2D3D4, 4'b1111, 1'b0);
    send_beat(32'hE1E20000, 4'b1100, 1'b1);

    // Backpressure: stall the first output beat for three cycles
    fork
      pkt_abc_n2();
      begin
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(posedge clk);
          #1;
          seen = bus.valid_out;
        end
        chk("bp_first_beat_timeout", 64'(seen), 64'(1'b1));
        bus.ready_out = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_data",     64'(bus.data_out),  64'(32'hA3A4B1B2));
          chk("bp_hold_keep",     64'(bus.keep_out),  64'(4'b1111));
          chk("bp_hold_last",     64'(bus.last_out),  64'(1'b0));
          chk("bp_ready_in_low",  64'(bus.ready_in),  64'(1'b0));
        end
        @(posedge clk);
        #1;
        bus.ready_out = 1'b1;
      end
    join

    // Reset in the middle of BODY
    exp_out(32'hA3A4B1B2, 4'b1111, 1'b0);
    exp_hdr(32'h0000A1A2, 4'b0011);
    send_cmd(4'b0011);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
    send_beat(32'hB1B2B3B4, 4'b1111, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid_out",   64'(bus.valid_out),   64'(1'b0));
    chk("midrst_ready_strip", 64'(bus.ready_strip), 64'(1'b0));
    chk("midrst_ready_in",    64'(bus.ready_in),    64'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt_abc_n2();

    // Drain and confirm nothing expected is left over
    for (int t = 0; t < 100 && oq.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("out_queue_empty", 64'(oq.size()), 64'(0));
`ifdef STRIP_HEADER_OUT_EN
    chk("hdr_queue_empty", 64'(hq.size()), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
